fetch_stage: RTL and testbench

Instruction fetch stage of the 16-bit pipelined core. It owns the program counter and issues word requests to instruction memory over a request/grant interface. Returned instructions go into a small prefetch FIFO, which presents {pc, instruction} to the IF/ID pipeline register. It also drives that register's load enable, and handles stall back-pressure and branch/jump redirects from EX.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 16-bit pipelined core.
// Owns the program counter, issues word requests over a request/grant
// memory port, buffers returned instructions in a small prefetch FIFO and
// presents {pc, instruction} to the IF/ID register. Redirects from EX flush
// the FIFO and mark already-issued requests so their responses are dropped.
module fetch_stage #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic             pipe_en
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] head_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic             in_reset_q;
  logic             hold_q;

  logic             pop;
  logic             do_pop;
  logic             do_write;
  logic             accept;
  logic             can_issue;
  logic [CW-1:0]    live;
  logic [CW:0]      occ_sum;
  logic [CW-1:0]    outstanding_next;

  // Issue decision and per-cycle bookkeeping terms
  always_comb begin
    pop       = 1'b0;
    live      = '0;
    occ_sum   = '0;
    can_issue = 1'b0;
    imem_req  = 1'b0;
    accept    = 1'b0;
    do_pop    = 1'b0;
    do_write  = 1'b0;
    outstanding_next = '0;

    pop     = (count != '0) && !stall;
    live    = outstanding - drop_cnt;
    occ_sum = (CW+1)'(live) + (CW+1)'(count) - (CW+1)'(pop);
    can_issue = (outstanding < CW'(DEPTH)) && (occ_sum < (CW+1)'(DEPTH));

    // The first cycle after reset always requests; a request that was not
    // granted keeps asserting so the memory sees a stable transaction.
    if (in_reset_q) imem_req = rst_n;
    else            imem_req = can_issue || hold_q;

    accept   = imem_req && imem_gnt;
    do_pop   = pop && !redirect_valid;
    do_write = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    outstanding_next = outstanding + CW'(accept) - CW'(imem_rvalid);
  end

  // PC, in-flight accounting and FIFO pointer state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_reset_q  <= 1'b1;
      hold_q      <= 1'b0;
    end else begin
      in_reset_q  <= 1'b0;
      hold_q      <= imem_req && !imem_gnt && !redirect_valid;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        head_pc  <= redirect_pc;
        drop_cnt <= outstanding_next;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + WIDTH'(1);
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (do_write) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          head_pc <= head_pc + WIDTH'(1);
        end
        count <= count + CW'(do_write) - CW'(do_pop);
      end
    end
  end

  // Prefetch FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (do_write) begin
      fifo_mem[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = fifo_mem[rd_ptr];
  assign out_pc    = head_pc;
  assign pipe_en   = !stall;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A bench-side memory
// answers granted requests after a programmable latency with addr ^ 16'hA5A5;
// every grant pushes the expected {pc, instr} into a queue, which is popped
// and compared whenever the stage hands an instruction to IF/ID.
module tb_fetch_stage;

  typedef struct {
    logic [15:0] addr;
    int          rdy;
  } mem_req_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        pipe_en;

  mem_req_t    mem_q[$];
  sb_entry_t   sb_q[$];
  int          mem_lat = 1;
  int          cyc = 0;
  logic [15:0] exp_fetch = 16'h0000;
  int          vec_count = 0;
  int          miss_count = 0;
  bit          found;

  fetch_stage #(.WIDTH(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .pipe_en        (pipe_en)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle at the falling edge, then do memory and scoreboard
  // bookkeeping mid-cycle; returns before the next rising edge.
  task automatic applyStimulus(input bit rs, input bit st, input bit gn,
                               input bit rd, input logic [15:0] rpc);
    sb_entry_t e;
    @(negedge clk);
    if (rs) begin
      rst_n       = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      mem_q.delete();
    end else begin
      rst_n = 1'b1;
      if (mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_q[0].addr ^ 16'hA5A5;
        void'(mem_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom_range(0, 65535));
      end
    end
    stall          = st;
    imem_gnt       = gn;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    if (rs) begin
      sb_q.delete();
      exp_fetch = 16'h0000;
    end else begin
      checkOutput("pipe_en", {15'b0, pipe_en}, {15'b0, ~st});
      if (imem_req && gn) begin
        checkOutput("imem_addr", imem_addr, exp_fetch);
        mem_q.push_back('{addr: exp_fetch, rdy: cyc + mem_lat});
        sb_q.push_back('{pc: exp_fetch, instr: exp_fetch ^ 16'hA5A5});
        exp_fetch = exp_fetch + 16'd1;
      end
      if (out_valid && !st && !rd) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underrun", {15'b0, out_valid}, 16'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("out_instr", out_instr, e.instr);
        end
      end
      if (rd) begin
        sb_q.delete();
        exp_fetch = rpc;
      end
    end
    cyc++;
  endtask

  initial begin
    // Reset held for two cycles; check reset values after the first edge
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(1, 0, 1, 0, 16'h0);
    checkOutput("rst_out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("rst_imem_req", {15'b0, imem_req}, 16'd0);
    checkOutput("rst_imem_addr", imem_addr, 16'h0000);
    checkOutput("rst_out_pc", out_pc, 16'h0000);
    checkOutput("rst_out_instr", out_instr, 16'h0000);

    // Streaming with 1-cycle memory: first request, 2-cycle latency, 1/cycle
    for (int c = 0; c < 7; c++) begin
      applyStimulus(0, 0, 1, 0, 16'h0);
      if (c == 0) begin
        checkOutput("first_req", {15'b0, imem_req}, 16'd1);
        checkOutput("first_addr", imem_addr, 16'h0000);
      end
      if (c == 1) checkOutput("lat_out_valid0", {15'b0, out_valid}, 16'd0);
      if (c >= 2) checkOutput("stream_valid", {15'b0, out_valid}, 16'd1);
    end

    // Stall for three cycles while pc 5 is at the head
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 16'h0);
      checkOutput("stall_valid", {15'b0, out_valid}, 16'd1);
      checkOutput("stall_pc", out_pc, 16'h0005);
      checkOutput("stall_instr", out_instr, 16'h0005 ^ 16'hA5A5);
      if (i >= 1) checkOutput("stall_req_drop", {15'b0, imem_req}, 16'd0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 16'h0);

    // Grant back-pressure: request and address must hold
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 16'h0);
      checkOutput("hold_req", {15'b0, imem_req}, 16'd1);
      checkOutput("hold_addr", imem_addr, exp_fetch);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 16'h0);

    // Redirect, response and stall all in the same cycle
    if (mem_q.size() == 0) applyStimulus(0, 0, 1, 0, 16'h0);
    applyStimulus(0, 1, 1, 1, 16'h0123);
    applyStimulus(0, 0, 1, 0, 16'h0);
    checkOutput("rsr_out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("rsr_addr_or_next", out_pc, 16'h0123);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(0, 0, 1, 0, 16'h0);
      if (out_valid) begin
        found = 1'b1;
        checkOutput("rsr_first_pc", out_pc, 16'h0123);
        checkOutput("rsr_first_instr", out_instr, 16'h0123 ^ 16'hA5A5);
      end
    end
    if (!found) checkOutput("rsr_timeout", {15'b0, out_valid}, 16'd1);

    // Redirect with two requests in flight (3-cycle memory)
    applyStimulus(1, 0, 1, 0, 16'h0);
    mem_lat = 3;
    applyStimulus(0, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 1, 16'h0040);
    checkOutput("inflight_req_max", {15'b0, imem_req}, 16'd0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    checkOutput("redir_out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("redir_addr", imem_addr, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      applyStimulus(0, 0, 1, 0, 16'h0);
      if (out_valid) begin
        found = 1'b1;
        checkOutput("redir_first_pc", out_pc, 16'h0040);
      end
    end
    if (!found) checkOutput("redir_timeout", {15'b0, out_valid}, 16'd1);

    // Reset in the middle of operation with the FIFO filled by a stall
    mem_lat = 1;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 16'h0);
    checkOutput("pre_reset_valid", {15'b0, out_valid}, 16'd1);
    applyStimulus(1, 1, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 0, 16'h0);
    checkOutput("mid_rst_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("mid_rst_addr", imem_addr, 16'h0000);
    checkOutput("mid_rst_req", {15'b0, imem_req}, 16'd1);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      applyStimulus(0, 0, 1, 0, 16'h0);
      if (out_valid) begin
        found = 1'b1;
        checkOutput("mid_rst_first_pc", out_pc, 16'h0000);
      end
    end
    if (!found) checkOutput("mid_rst_timeout", {15'b0, out_valid}, 16'd1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
